// File: rtl/time_display_driver.sv
// Converts a seconds count to HH:MM:SS on six active-low 7-segment digits using
// an iterative subtract FSM (no dividers), with per-field 1 Hz blink blanking.
module time_display_driver #(
  parameter int MAX_SEC    = 86399,
  parameter int BLINK_HALF = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] sec_in,
  input  logic        blink_hr,
  input  logic        blink_min,
  input  logic        blink_sec,
  output logic [6:0]  hex5,
  output logic [6:0]  hex4,
  output logic [6:0]  hex3,
  output logic [6:0]  hex2,
  output logic [6:0]  hex1,
  output logic [6:0]  hex0,
  output logic        busy,
  output logic        ovr
);

  typedef enum logic [2:0] {S_IDLE, S_HRS, S_MINS, S_TENS, S_LOAD} state_e;

  localparam logic [16:0] MAX_V      = 17'(MAX_SEC);
  localparam int          CW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_HALF - 1);
  localparam logic [6:0]  BLANK      = 7'h7F;

  state_e            state_q, state_d;
  logic [16:0]       last_val_q, last_val_d;
  logic [16:0]       rem_q, rem_d;
  logic [4:0]        hrs_q, hrs_d;
  logic [5:0]        mins_q, mins_d;
  logic [5:0]        secs_q, secs_d;
  logic              ovr_pending_q, ovr_pending_d;
  logic              ovr_q, ovr_d;
  // Digit index 5..0 = hour tens/units, minute tens/units, second tens/units.
  logic [5:0][3:0]   work_q, work_d;
  logic [5:0][3:0]   disp_q, disp_d;
  logic [CW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;

  // Every state update happens on the falling edge of clk.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      last_val_q    <= '0;
      rem_q         <= '0;
      hrs_q         <= '0;
      mins_q        <= '0;
      secs_q        <= '0;
      ovr_pending_q <= 1'b0;
      ovr_q         <= 1'b0;
      work_q        <= '0;
      disp_q        <= '0;
      blink_cnt_q   <= '0;
      phase_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking here so every flop samples the pre-edge values of the others.
      state_q       <= state_d;
      last_val_q    <= last_val_d;
      rem_q         <= rem_d;
      hrs_q         <= hrs_d;
      mins_q        <= mins_d;
      secs_q        <= secs_d;
      ovr_pending_q <= ovr_pending_d;
      ovr_q         <= ovr_d;
      work_q        <= work_d;
      disp_q        <= disp_d;
      blink_cnt_q   <= blink_cnt_d;
      phase_q       <= phase_d;
    end
  end

  always_comb begin
    // NOTE: hold-by-default assignments first, so no branch can infer a latch.
    state_d       = state_q;
    last_val_d    = last_val_q;
    rem_d         = rem_q;
    hrs_d         = hrs_q;
    mins_d        = mins_q;
    secs_d        = secs_q;
    ovr_pending_d = ovr_pending_q;
    ovr_d         = ovr_q;
    work_d        = work_q;
    disp_d        = disp_q;

    case (state_q)
      S_IDLE: begin
        if (sec_in != last_val_q) begin
          last_val_d    = sec_in;
          ovr_pending_d = (sec_in > MAX_V);
          rem_d         = (sec_in > MAX_V) ? MAX_V : sec_in;
          hrs_d         = '0;
          mins_d        = '0;
          work_d        = '0;
          state_d       = S_HRS;
        end
      end
      S_HRS: begin
        if (rem_q >= 17'd3600) begin
          rem_d = rem_q - 17'd3600;
          hrs_d = hrs_q + 5'd1;
        end else begin
          state_d = S_MINS;
        end
      end
      S_MINS: begin
        if (rem_q >= 17'd60) begin
          rem_d  = rem_q - 17'd60;
          mins_d = mins_q + 6'd1;
        end else begin
          secs_d  = rem_q[5:0];
          state_d = S_TENS;
        end
      end
      S_TENS: begin
        if ((hrs_q >= 5'd10) || (mins_q >= 6'd10) || (secs_q >= 6'd10)) begin
          if (hrs_q >= 5'd10) begin
            hrs_d     = hrs_q - 5'd10;
            work_d[5] = work_q[5] + 4'd1;
          end
          if (mins_q >= 6'd10) begin
            mins_d    = mins_q - 6'd10;
            work_d[3] = work_q[3] + 4'd1;
          end
          if (secs_q >= 6'd10) begin
            secs_d    = secs_q - 6'd10;
            work_d[1] = work_q[1] + 4'd1;
          end
        end else begin
          work_d[4] = hrs_q[3:0];
          work_d[2] = mins_q[3:0];
          work_d[0] = secs_q[3:0];
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        disp_d  = work_q;
        ovr_d   = ovr_pending_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!(blink_hr || blink_min || blink_sec)) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = BLANK;
    endcase
  endfunction

  assign hex5 = (blink_hr  && phase_q) ? BLANK : seg7(disp_q[5]);
  assign hex4 = (blink_hr  && phase_q) ? BLANK : seg7(disp_q[4]);
  assign hex3 = (blink_min && phase_q) ? BLANK : seg7(disp_q[3]);
  assign hex2 = (blink_min && phase_q) ? BLANK : seg7(disp_q[2]);
  assign hex1 = (blink_sec && phase_q) ? BLANK : seg7(disp_q[1]);
  assign hex0 = (blink_sec && phase_q) ? BLANK : seg7(disp_q[0]);

  assign busy = (state_q != S_IDLE);
  assign ovr  = ovr_q;

endmodule

// File: tb/tb_time_display_driver.sv
// Randomized bench for time_display_driver; expected display, latency and blink
// phase come from plain div/mod arithmetic on the seconds value and edge count.
module tb_time_display_driver;

  localparam int BH   = 4;
  localparam int MAXS = 86399;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [16:0] sec_in = '0;
  logic        blink_hr = 1'b0, blink_min = 1'b0, blink_sec = 1'b0;
  logic [6:0]  hex5, hex4, hex3, hex2, hex1, hex0;
  logic        busy, ovr;

  int checks = 0;
  int errors = 0;

  int          last_val = 0;
  logic [41:0] cur_disp;
  logic        cur_ovr = 1'b0;

  time_display_driver #(.MAX_SEC(MAXS), .BLINK_HALF(BH)) dut (
    .clk(clk), .rst(rst), .sec_in(sec_in),
    .blink_hr(blink_hr), .blink_min(blink_min), .blink_sec(blink_sec),
    .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .busy(busy), .ovr(ovr)
  );

  always #10 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int clampv(input int v);
    return (v > MAXS) ? MAXS : v;
  endfunction

  function automatic logic [41:0] exp_disp(input int v);
    int c, h, m, s;
    c = clampv(v);
    h = c / 3600;
    m = (c % 3600) / 60;
    s = c % 60;
    return {seg(h / 10), seg(h % 10), seg(m / 10), seg(m % 10), seg(s / 10), seg(s % 10)};
  endfunction

  function automatic int exp_lat(input int v);
    int c, h, m, s, t;
    c = clampv(v);
    h = c / 3600;
    m = (c % 3600) / 60;
    s = c % 60;
    t = h / 10;
    if (m / 10 > t) t = m / 10;
    if (s / 10 > t) t = s / 10;
    return h + m + t + 5;
  endfunction

  function automatic logic [41:0] blinked(input logic [41:0] d, input logic [2:0] mask, input int k);
    logic [41:0] e;
    logic ph;
    e  = d;
    ph = ((k / BH) % 2) == 1;
    if (mask[2] && ph) e[41:28] = {7'h7F, 7'h7F};
    if (mask[1] && ph) e[27:14] = {7'h7F, 7'h7F};
    if (mask[0] && ph) e[13:0]  = {7'h7F, 7'h7F};
    return e;
  endfunction

  function automatic logic [41:0] disp();
    return {hex5, hex4, hex3, hex2, hex1, hex0};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Drives v and follows the conversion edge by edge against the model.
  task automatic run_conversion(input int v, input string name);
    int          lat;
    logic [41:0] ed;
    logic        eo;
    sec_in = 17'(v);
    if (v == last_val) begin
      tick();
      checks++;
      if (busy !== 1'b0 || disp() !== cur_disp) begin
        errors++;
        $display("FAIL %s no-change: busy=%b disp=%h, want busy=0 disp=%h", name, busy, disp(), cur_disp);
      end
      return;
    end
    lat = exp_lat(v);
    ed  = exp_disp(v);
    eo  = (v > MAXS);
    for (int e = 1; e <= lat; e++) begin
      tick();
      if (e < lat) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy edge %0d: got %b want 1", name, e, busy);
        end
        if (e == lat - 1) begin
          checks++;
          if (disp() !== cur_disp || ovr !== cur_ovr) begin
            errors++;
            $display("FAIL %s hold edge %0d: disp=%h ovr=%b want disp=%h ovr=%b",
                     name, e, disp(), ovr, cur_disp, cur_ovr);
          end
        end
      end else begin
        checks++;
        if (disp() !== ed || ovr !== eo || busy !== 1'b0) begin
          errors++;
          $display("FAIL %s load edge %0d: disp=%h ovr=%b busy=%b want disp=%h ovr=%b busy=0",
                   name, e, disp(), ovr, busy, ed, eo);
        end
      end
    end
    last_val = v;
    cur_disp = ed;
    cur_ovr  = eo;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sec_in    = 17'($urandom_range(0, 131071));
      blink_hr  = 1'($urandom);
      blink_min = 1'($urandom);
      blink_sec = 1'($urandom);
      tick();
      checks++;
      if (disp() !== {6{7'h40}} || busy !== 1'b0 || ovr !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: disp=%h busy=%b ovr=%b want all 40, 0, 0", disp(), busy, ovr);
      end
    end
    blink_hr = 1'b0; blink_min = 1'b0; blink_sec = 1'b0;
    sec_in   = '0;
    rst      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || disp() !== {6{7'h40}}) begin
        errors++;
        $display("FAIL reset_release: busy=%b disp=%h want 0 and all 40", busy, disp());
      end
    end
    last_val = 0;
    cur_disp = {6{7'h40}};
    cur_ovr  = 1'b0;
  endtask

  task automatic test_basic();
    run_conversion(3725, "basic_3725");
    checks++;
    if (disp() !== {7'h40, 7'h79, 7'h40, 7'h24, 7'h40, 7'h12}) begin
      errors++;
      $display("FAIL basic_literal: disp=%h want 40794024_4012", disp());
    end
  endtask

  task automatic test_clamp();
    run_conversion(86399, "max_86399");
    run_conversion(90000, "clamp_90000");
    run_conversion(59, "after_clamp_59");
    run_conversion(131071, "clamp_top");
    run_conversion(86400, "clamp_86400");
    run_conversion(0, "zero");
  endtask

  task automatic test_back_to_back(input int v1, input int v2, input int change_at, input string name);
    int lat1, lat2;
    sec_in = 17'(v1);
    lat1 = exp_lat(v1);
    for (int e = 1; e <= lat1; e++) begin
      tick();
      if (e == change_at - 1) sec_in = 17'(v2);
    end
    checks++;
    if (disp() !== exp_disp(v1) || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s first: disp=%h busy=%b want disp=%h busy=0", name, disp(), busy, exp_disp(v1));
    end
    last_val = v1;
    cur_disp = exp_disp(v1);
    cur_ovr  = (v1 > MAXS);
    run_conversion(v2, name);
  endtask

  task automatic test_blink_min();
    logic [41:0] e;
    run_conversion(3725, "blink_setup");
    blink_min = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      if (k > 0) tick();
      e = blinked(cur_disp, 3'b010, k);
      checks++;
      if (disp() !== e) begin
        errors++;
        $display("FAIL blink_min k=%0d: disp=%h want %h", k, disp(), e);
      end
    end
    for (int k = 12; k <= 13; k++) tick();  // k=13 lands in a blank phase
    blink_min = 1'b0;
    #1;
    checks++;
    if (disp() !== cur_disp) begin
      errors++;
      $display("FAIL blink_drop: disp=%h want %h", disp(), cur_disp);
    end
    tick();
  endtask

  task automatic test_blink_random();
    logic [2:0]  mask;
    logic [41:0] e;
    for (int n = 0; n < 4; n++) begin
      mask = 3'($urandom_range(1, 7));
      {blink_hr, blink_min, blink_sec} = mask;
      for (int k = 0; k < 10; k++) begin
        if (k > 0) tick();
        e = blinked(cur_disp, mask, k);
        checks++;
        if (disp() !== e) begin
          errors++;
          $display("FAIL blink_rand mask=%b k=%0d: disp=%h want %h", mask, k, disp(), e);
        end
      end
      {blink_hr, blink_min, blink_sec} = 3'b000;
      tick();
      checks++;
      if (disp() !== cur_disp) begin
        errors++;
        $display("FAIL blink_rand_off mask=%b: disp=%h want %h", mask, disp(), cur_disp);
      end
    end
  endtask

  task automatic test_reset_mid();
    if (last_val == 86399) run_conversion(0, "pre_reset_mid");
    sec_in = 17'd86399;
    for (int e = 1; e <= 5; e++) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_busy: got %b want 1", busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (disp() !== {6{7'h40}} || busy !== 1'b0 || ovr !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_abort: disp=%h busy=%b ovr=%b want all 40, 0, 0", disp(), busy, ovr);
    end
    tick();
    tick();
    rst      = 1'b1;
    last_val = 0;
    cur_disp = {6{7'h40}};
    cur_ovr  = 1'b0;
    run_conversion(86399, "reset_mid_reconvert");
  endtask

  task automatic test_random();
    int v, v2;
    for (int n = 0; n < 10; n++) begin
      v = (n % 4 == 3) ? int'($urandom_range(86400, 131071)) : int'($urandom_range(0, 86399));
      run_conversion(v, "random");
    end
    for (int n = 0; n < 4; n++) begin
      v  = int'($urandom_range(0, 86399));
      v2 = int'($urandom_range(0, 131071));
      if (v == last_val) v = (v + 1) % 86400;
      if (v2 == v) v2 = v + 1;
      test_back_to_back(v, v2, int'($urandom_range(2, 4)), "random_b2b");
    end
  endtask

  initial begin
    cur_disp = {6{7'h40}};
    test_reset();
    test_basic();
    test_clamp();
    test_back_to_back((last_val == 3725) ? 3726 : 3725, 59, 3, "b2b_3725_59");
    test_blink_min();
    test_blink_random();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
